debounce_core: RTL and testbench
================================

DEBOUNCE_CORE -- requirements
Module: debounce_core

Interface
REQ-001 Parameter W, default 8: number of debounced input bits, 1..32.
REQ-002 Parameter LIMIT_DEF, default 500000: reset value of the tick-period register.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  slot select.
REQ-006 read  input  1  slot read strobe (qualified by cs).
REQ-007 write  input  1  slot write strobe (qualified by cs).
REQ-008 addr  input  5  slot register address.
REQ-009 wr_data  input  32  slot write data.
REQ-010 rd_data  output  32  slot read data.
REQ-011 din  input  W  raw asynchronous external inputs (switches/buttons).
REQ-012 dout  output  W  debounced inputs, fed directly to the downstream GPI core's sampling input.
REQ-013 irq  output  1  level interrupt; present only with DEB_IRQ_EN.

Function
REQ-014 din SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-015 Prescaler: counter 0..LIMIT-1 SHALL emit a 1-cycle tick when at LIMIT-1, then wrap to 0; LIMIT=0 is treated as 1 (tick every cycle).
REQ-016 Per-bit FSM states: LO, WAIT_HI, HI, WAIT_LO; dout bit = 1 in HI and WAIT_LO, else 0.
REQ-017 LO->WAIT_HI on tick with sync=1; WAIT_HI->HI after 4 consecutive ticks with sync=1, ->LO on any tick with sync=0; HI/WAIT_LO mirror this.
REQ-018 Per-bit 2-bit tick counter SHALL clear on entering any WAIT state and on return to LO/HI.
REQ-019 dout change latency from a clean din step: between 3*LIMIT+3 and 4*LIMIT+3 cycles; glitches shorter than LIMIT cycles SHALL never reach dout.
REQ-020 Register map (word addr): 0 R dout, zero-extended; 1 R/W1C rise-capture; 2 R/W tick period LIMIT[31:0]; 3 R/W irq mask (DEB_IRQ_EN only); other addresses read 0, writes ignored.
REQ-021 Rise-capture bit i SHALL set on the cycle dout[i] goes 0->1; a cs&write to addr 1 clears bits where wr_data=1.
REQ-022 Simultaneous set and clear on one bit: set wins.
REQ-023 Write to addr 2 SHALL restart the prescaler at 0 on the next cycle; FSM states are preserved.
REQ-024 rd_data SHALL be a combinational mux of registered state on addr; read has no side effects.
REQ-025 Writes without cs SHALL be ignored; bits above W in reads SHALL be 0.

Reset
REQ-026 On reset: synchronizers, prescaler, tick counters cleared; all FSMs to LO; dout=0; capture=0; LIMIT=LIMIT_DEF; mask=0; irq=0.
REQ-027 Reset asserted mid-debounce SHALL abandon the pending transition; no capture bit set for it.

Configuration
REQ-028 Macro DEB_IRQ_EN defined: addr-3 mask register and irq = |(capture & mask), registered (1-cycle after capture sets).
REQ-029 Macro DEB_IRQ_EN undefined: no irq port, no mask register; addr 3 reads 0.

Structure
REQ-030 Package deb_pkg SHALL hold the FSM state enum, register address constants (ADDR_DATA, ADDR_EDGE, ADDR_LIMIT, ADDR_MASK) and tick-count threshold 4.
REQ-031 Per-bit synchronizer+FSM SHALL be sub-module deb_cell, instantiated W times by generate; prescaler and slot registers stay in debounce_core.

Verification
REQ-032 LIMIT=1, din[0] 0->1 held -> dout[0]=1 within 4..7 cycles; capture reads 0x01.
REQ-033 LIMIT=10, din[3] pulsed high for 8 cycles -> dout stays 0x00, capture stays 0.
REQ-034 Capture=0x05, write 0x04 to addr 1 -> reads 0x01; write coinciding with a new rise on bit 2 -> bit 2 stays 1.
REQ-035 Reset asserted 2 ticks into WAIT_HI -> dout=0, capture=0, LIMIT reads LIMIT_DEF after release.
REQ-036 DEB_IRQ_EN, mask=0x02, rise on bit 1 -> irq=1 one cycle after capture; clearing capture bit 1 -> irq=0 next cycle.

Source files
------------

// File: rtl/deb_pkg.sv
// Shared types and constants for the debounce block: per-bit FSM states,
// slot register word addresses and the debounce tick threshold.
package deb_pkg;

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } deb_state_t;

    localparam logic [4:0] ADDR_DATA  = 5'd0;
    localparam logic [4:0] ADDR_EDGE  = 5'd1;
    localparam logic [4:0] ADDR_LIMIT = 5'd2;
    localparam logic [4:0] ADDR_MASK  = 5'd3;

    // Number of consecutive agreeing ticks needed to accept a new level.
    // The tick that moves the FSM into a WAIT state is the first of them,
    // so the counter only has to see TICK_THRESH-1 more ticks in WAIT.
    localparam int         TICK_THRESH = 4;
    localparam logic [1:0] TICK_LAST   = 2'(TICK_THRESH - 2);

endpackage

// File: rtl/deb_cell.sv
// One debounced input bit: two-flop synchronizer followed by the
// LO / WAIT_HI / HI / WAIT_LO filter that only advances on prescaler ticks.
// rise pulses on the same cycle the debounced output turns 0->1.
module deb_cell
    import deb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic tick,
    output logic dout,
    output logic rise
);

    logic [1:0] sync_q;
    logic       sync;
    deb_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    assign sync = sync_q[1];

    // Bring the raw asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], din};
    end

    // State and agreeing-tick counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LO;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: every decision is taken on a tick; a disagreeing sample
    // during a WAIT state drops straight back to the stable level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                ST_LO: begin
                    if (sync) begin
                        state_d = ST_WAIT_HI;
                        cnt_d   = 2'd0;
                    end
                end
                ST_WAIT_HI: begin
                    if (!sync) begin
                        state_d = ST_LO;
                        cnt_d   = 2'd0;
                    end else if (cnt_q == TICK_LAST) begin
                        state_d = ST_HI;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                ST_HI: begin
                    if (!sync) begin
                        state_d = ST_WAIT_LO;
                        cnt_d   = 2'd0;
                    end
                end
                ST_WAIT_LO: begin
                    if (sync) begin
                        state_d = ST_HI;
                        cnt_d   = 2'd0;
                    end else if (cnt_q == TICK_LAST) begin
                        state_d = ST_LO;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d = ST_LO;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    assign dout = (state_q == ST_HI) || (state_q == ST_WAIT_LO);
    assign rise = (state_q == ST_WAIT_HI) && (state_d == ST_HI);

endmodule

// File: rtl/debounce_core.sv
// Debounce slot: W debounced inputs with a programmable tick prescaler,
// a W1C rise-capture register and a small register slot interface.
// Optional feature macro DEB_IRQ_EN adds an irq mask register at word
// address 3 and a registered level interrupt output irq.
module debounce_core
    import deb_pkg::*;
#(
    parameter int          W         = 8,
    parameter logic [31:0] LIMIT_DEF = 32'd500000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
`ifdef DEB_IRQ_EN
    ,
    output logic          irq
`endif
);

    logic          wr_en;
    logic [31:0]   limit_q;
    logic [31:0]   limit_eff;
    logic [31:0]   pre_cnt_q;
    logic          tick;
    logic [W-1:0]  rise;
    logic [W-1:0]  capture_q;
    logic [W-1:0]  capture_clr;
    logic [31:0]   rd_mux;
    logic          unused_read;

    // Reads are side-effect free, so the strobe carries no information here.
    assign unused_read = read;

    assign wr_en       = cs & write;
    assign limit_eff   = (limit_q == 32'd0) ? 32'd1 : limit_q;
    assign tick        = (pre_cnt_q >= (limit_eff - 32'd1));
    assign capture_clr = (wr_en && addr == ADDR_EDGE) ? wr_data[W-1:0] : '0;

    // Tick period register.
    always_ff @(posedge clk) begin
        if (reset)                          limit_q <= LIMIT_DEF;
        else if (wr_en && addr == ADDR_LIMIT) limit_q <= wr_data;
    end

    // Prescaler: restarts from zero whenever a new period is written.
    always_ff @(posedge clk) begin
        if (reset)                            pre_cnt_q <= 32'd0;
        else if (wr_en && addr == ADDR_LIMIT) pre_cnt_q <= 32'd0;
        else if (tick)                        pre_cnt_q <= 32'd0;
        else                                  pre_cnt_q <= pre_cnt_q + 32'd1;
    end

    for (genvar i = 0; i < W; i++) begin : g_cell
        deb_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .din   (din[i]),
            .tick  (tick),
            .dout  (dout[i]),
            .rise  (rise[i])
        );
    end

    // Rise capture: software clears with write-one, a fresh rise always wins.
    always_ff @(posedge clk) begin
        if (reset) capture_q <= '0;
        else       capture_q <= (capture_q & ~capture_clr) | rise;
    end

`ifdef DEB_IRQ_EN
    logic [W-1:0] mask_q;

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (reset)                           mask_q <= '0;
        else if (wr_en && addr == ADDR_MASK) mask_q <= wr_data[W-1:0];
    end

    // Registered interrupt level, one cycle behind the capture register.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(capture_q & mask_q);
    end
`endif

    // Read mux over registered state; unused upper bits stay zero.
    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            ADDR_DATA:  rd_mux[W-1:0] = dout;
            ADDR_EDGE:  rd_mux[W-1:0] = capture_q;
            ADDR_LIMIT: rd_mux        = limit_q;
`ifdef DEB_IRQ_EN
            ADDR_MASK:  rd_mux[W-1:0] = mask_q;
`endif
            default:    rd_mux        = 32'd0;
        endcase
    end

    assign rd_data = rd_mux;

endmodule

// File: tb/tb_debounce_core.sv
// Self-checking bench for debounce_core: a register-access vector table
// plus directed multi-cycle sequences for latency, glitch rejection,
// capture set/clear priority, mid-debounce reset and (with DEB_IRQ_EN) irq.
module tb_debounce_core;

    localparam int          W         = 8;
    localparam logic [31:0] LIMIT_DEF = 32'd500000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          read;
    logic          write;
    logic [4:0]    addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
`ifdef DEB_IRQ_EN
    logic          irq;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    debounce_core #(.W(W), .LIMIT_DEF(LIMIT_DEF)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .dout    (dout)
`ifdef DEB_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        total++;
        if (actual < lo || actual > hi) begin
            bad++;
            $display("[TB] FAIL %s: got %0d cycles expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic writeReg(input logic [4:0] a, input logic [31:0] d, input logic sel);
        cs      = sel;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        cs    = 1'b0;
        write = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] d);
        cs   = 1'b1;
        read = 1'b1;
        addr = a;
        #1;
        d    = rd_data;
        cs   = 1'b0;
        read = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDout(input int b, input logic v, input int budget, output int cycles);
        cycles = 0;
        while (dout[b] !== v && cycles < budget) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] d;
        if (v.wr) writeReg(v.addr, v.wdata, v.cs);
        readReg(v.addr, d);
        checkOutput(v.name, d, v.exp);
    endtask

    initial begin
        logic [31:0] d;
        int          c;
        logic [W-1:0] seen;

        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; din = '0;

        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,     "data_rst"};
        vecs[1]  = '{1'b1, 1'b0, 5'd1,  32'h0,        32'h0,     "edge_rst"};
        vecs[2]  = '{1'b1, 1'b0, 5'd2,  32'h0,        LIMIT_DEF, "limit_rst"};
        vecs[3]  = '{1'b1, 1'b0, 5'd3,  32'h0,        32'h0,     "addr3_rst"};
        vecs[4]  = '{1'b1, 1'b0, 5'd9,  32'h0,        32'h0,     "addr9_rd"};
        vecs[5]  = '{1'b1, 1'b1, 5'd2,  32'h1234,     32'h1234,  "limit_wr"};
        vecs[6]  = '{1'b0, 1'b1, 5'd2,  32'hBEEF,     32'h1234,  "limit_nocs"};
        vecs[7]  = '{1'b1, 1'b1, 5'd6,  32'hFFFFFFFF, 32'h0,     "addr6_wr"};
        vecs[8]  = '{1'b1, 1'b1, 5'd0,  32'hFF,       32'h0,     "data_ro"};
        vecs[9]  = '{1'b1, 1'b1, 5'd1,  32'hFF,       32'h0,     "edge_w1c_idle"};
        vecs[10] = '{1'b1, 1'b1, 5'd2,  32'h0,        32'h0,     "limit_zero"};

        @(negedge clk);
        doReset();
        checkOutput("dout_rst", 32'(dout), 32'h0);

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Rising step with a one-cycle tick period.
        writeReg(5'd2, 32'd1, 1'b1);
        din[0] = 1'b1;
        waitDout(0, 1'b1, 20, c);
        checkRange("lat_rise_lim1", c, 4, 7);
        readReg(5'd1, d);
        checkOutput("cap_after_rise0", d, 32'h01);
        readReg(5'd0, d);
        checkOutput("data_after_rise0", d, 32'h01);

        // Falling step with period 0, which must behave like period 1.
        writeReg(5'd2, 32'd0, 1'b1);
        din[0] = 1'b0;
        waitDout(0, 1'b0, 20, c);
        checkRange("lat_fall_lim0", c, 6, 7);
        readReg(5'd1, d);
        checkOutput("cap_fall_keeps", d, 32'h01);

        // Rising step with period 3.
        writeReg(5'd2, 32'd3, 1'b1);
        din[1] = 1'b1;
        waitDout(1, 1'b1, 40, c);
        checkRange("lat_rise_lim3", c, 12, 15);
        readReg(5'd1, d);
        checkOutput("cap_bits01", d, 32'h03);

        // An 8-cycle pulse against a 10-cycle tick never reaches dout.
        writeReg(5'd1, 32'hFF, 1'b1);
        readReg(5'd1, d);
        checkOutput("cap_cleared", d, 32'h0);
        writeReg(5'd2, 32'd10, 1'b1);
        seen = 8'h02;
        din[3] = 1'b1;
        repeat (8) @(negedge clk);
        din[3] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dout !== 8'h02 && seen == 8'h02) seen = dout;
        end
        checkOutput("glitch_dout", 32'(seen), 32'h02);
        readReg(5'd1, d);
        checkOutput("glitch_cap", d, 32'h0);

        // Partial clear, then a clear landing on the same cycle as a rise.
        doReset();
        writeReg(5'd2, 32'd1, 1'b1);
        din = 8'h05;
        waitDout(2, 1'b1, 20, c);
        repeat (3) @(negedge clk);
        readReg(5'd1, d);
        checkOutput("cap_05", d, 32'h05);
        writeReg(5'd1, 32'h04, 1'b1);
        readReg(5'd1, d);
        checkOutput("cap_clr_bit2", d, 32'h01);
        din[2] = 1'b0;
        waitDout(2, 1'b0, 20, c);
        checkRange("lat_fall_bit2", c, 6, 7);
        din[2] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_coincide_dout2", 32'(dout[2]), 32'h0);
        writeReg(5'd1, 32'h04, 1'b1);
        checkOutput("post_coincide_dout2", 32'(dout[2]), 32'h1);
        readReg(5'd1, d);
        checkOutput("set_beats_clear", d, 32'h05);

        // Reset two ticks into WAIT_HI abandons the pending rise.
        writeReg(5'd1, 32'hFF, 1'b1);
        din = 8'h00;
        repeat (12) @(negedge clk);
        din[1] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_dout1", 32'(dout[1]), 32'h0);
        reset = 1'b1;
        din   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_mid_dout", 32'(dout), 32'h0);
        readReg(5'd1, d);
        checkOutput("rst_mid_cap", d, 32'h0);
        readReg(5'd2, d);
        checkOutput("rst_mid_limit", d, LIMIT_DEF);
        repeat (10) @(negedge clk);
        readReg(5'd1, d);
        checkOutput("rst_mid_cap_later", d, 32'h0);

`ifdef DEB_IRQ_EN
        // Masked capture drives irq one cycle later; clearing drops it.
        writeReg(5'd2, 32'd1, 1'b1);
        writeReg(5'd3, 32'h02, 1'b1);
        readReg(5'd3, d);
        checkOutput("mask_rd", d, 32'h02);
        checkOutput("irq_idle", 32'(irq), 32'h0);
        din[1] = 1'b1;
        c = 0;
        readReg(5'd1, d);
        while (d[1] !== 1'b1 && c < 20) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            readReg(5'd1, d);
        end
        checkOutput("irq_cap_seen", d, 32'h02);
        checkOutput("irq_lag", 32'(irq), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("irq_set", 32'(irq), 32'h1);
        writeReg(5'd1, 32'h02, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("irq_clear", 32'(irq), 32'h0);
`else
        writeReg(5'd3, 32'hFF, 1'b1);
        readReg(5'd3, d);
        checkOutput("addr3_no_irq", d, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
